// File: rtl/hazard_ctrl_pkg.sv
// Shared core types for the 5-stage RV32I pipeline plus the hazard controller's
// state encoding and the hardwired-zero register index.
package hazard_ctrl_pkg;

    typedef logic [31:0] data_t;
    typedef logic        enable_t;
    typedef logic [4:0]  reg_addr_t;

    // Write-back source selected in the ID2EX buffer; WB_MEM marks a load.
    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_IMM = 2'd3
    } wb_data_sel_t;

    // RUN: normal flow. MEM_WAIT: a data-memory access is still outstanding.
    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hazard_state_t;

    // x0 reads as zero, so a write to it can never create a dependency.
    localparam reg_addr_t REG_ZERO = 5'd0;

    // True when an ID source operand is actually read and names register rd.
    function automatic logic src_hit(input enable_t use_c, input reg_addr_t rs,
                                     input reg_addr_t rd);
        return use_c & (rs == rd);
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;
    logic             w_full;

    assign w_full  = &r_count;
    assign o_count = r_count;

    // Count one per enabled cycle until the counter is full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && !w_full) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, EX redirect flushes and
// data-memory wait freezes, with saturating perf counters and a sticky
// memory-timeout flag.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  reg_addr_t    id_rs1_i,
    input  reg_addr_t    id_rs2_i,
    input  enable_t      id_use_rs1_c_i,
    input  enable_t      id_use_rs2_c_i,
    input  reg_addr_t    ex_rd_i,
    input  logic         ex_reg_write_c_i,
    input  wb_data_sel_t ex_wb_data_sel_c_i,
    input  logic         ex_redirect_c_i,
    input  logic         mem_req_c_i,
    input  logic         mem_ready_c_i,
    output logic         pc_stall_c_o,
    output logic         if2id_stall_c_o,
    output logic         if2id_flush_c_o,
    output logic         id2ex_stall_c_o,
    output logic         id2ex_flush_c_o,
    output logic         ex2mem_stall_c_o,
    output logic         mem2wb_flush_c_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o,
    output logic         err_timeout_o
);

    // The first wait cycle is spent in RUN (entry), so the counter in
    // MEM_WAIT only needs to reach MEM_TIMEOUT-2 for the flag to set at the
    // end of wait cycle number MEM_TIMEOUT.
    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        WAIT_W'((MEM_TIMEOUT > 2) ? (MEM_TIMEOUT - 2) : 0);
    localparam logic TIMEOUT_ON_ENTRY = (MEM_TIMEOUT <= 1);

    hazard_state_t     r_state;
    hazard_state_t     w_state_next;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_err_timeout;

    logic w_mem_wait;
    logic w_load_use;
    logic w_rd_is_load;
    logic w_timeout_hit;

    assign w_mem_wait   = mem_req_c_i & ~mem_ready_c_i;
    assign w_rd_is_load = ex_reg_write_c_i & (ex_wb_data_sel_c_i == WB_MEM) &
                          (ex_rd_i != REG_ZERO);
    assign w_load_use   = w_rd_is_load &
                          (src_hit(id_use_rs1_c_i, id_rs1_i, ex_rd_i) |
                           src_hit(id_use_rs2_c_i, id_rs2_i, ex_rd_i));

    assign w_timeout_hit = w_mem_wait &
                           (((r_state == MEM_WAIT) && (r_wait_cnt == WAIT_LAST)) |
                            TIMEOUT_ON_ENTRY);

    assign err_timeout_o = r_err_timeout;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and control decode; mem_wait beats redirect beats load_use.
    always_comb begin
        w_state_next     = r_state;
        pc_stall_c_o     = 1'b0;
        if2id_stall_c_o  = 1'b0;
        if2id_flush_c_o  = 1'b0;
        id2ex_stall_c_o  = 1'b0;
        id2ex_flush_c_o  = 1'b0;
        ex2mem_stall_c_o = 1'b0;
        mem2wb_flush_c_o = 1'b0;

        case (r_state)
            RUN:      if (w_mem_wait) w_state_next = MEM_WAIT;
            MEM_WAIT: if (mem_ready_c_i || !mem_req_c_i) w_state_next = RUN;
            default:  w_state_next = RUN;
        endcase

        if (w_mem_wait) begin
            // Freeze everything up to MEM; EX keeps its redirect/load for later.
            pc_stall_c_o     = 1'b1;
            if2id_stall_c_o  = 1'b1;
            id2ex_stall_c_o  = 1'b1;
            ex2mem_stall_c_o = 1'b1;
            mem2wb_flush_c_o = 1'b1;
        end else if (ex_redirect_c_i) begin
            // Wrong-path IF and ID are squashed, so their load-use is moot.
            if2id_flush_c_o  = 1'b1;
            id2ex_flush_c_o  = 1'b1;
        end else if (w_load_use) begin
            pc_stall_c_o     = 1'b1;
            if2id_stall_c_o  = 1'b1;
            id2ex_flush_c_o  = 1'b1;
        end
    end

    // Wait-length counter and sticky timeout flag; the stall is never aborted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt    <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            if ((r_state == RUN) && w_mem_wait) begin
                r_wait_cnt <= '0;
            end else if ((r_state == MEM_WAIT) && w_mem_wait &&
                         (r_wait_cnt != WAIT_LAST)) begin
                r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            end
            if (w_timeout_hit) begin
                r_err_timeout <= 1'b1;
            end
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (1'b0),
        .i_inc   (pc_stall_c_o),
        .o_count (stall_cnt_o)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (1'b0),
        .i_inc   (id2ex_flush_c_o),
        .o_count (flush_cnt_o)
    );

endmodule
